// File: rtl/i2c_byte_master_pkg.sv
// Shared types and constants for the I2C byte master: FSM state encoding,
// register map addresses, CMD/STATUS bit positions and phase sequencing helper.
package i2c_byte_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_STOP  = 3'd4
    } state_e;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CMD  = 2'd1;
    localparam logic [1:0] ADDR_DIV  = 2'd2;

    localparam int CMD_START   = 0;
    localparam int CMD_STOP    = 1;
    localparam int CMD_WRITE   = 2;
    localparam int CMD_READ    = 3;
    localparam int CMD_ACK_OUT = 4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_RX_NACK = 1;
    localparam int STAT_DONE    = 2;

    // Phase that follows 'cur' given the requested phases. WRITE wins over
    // READ when both are requested; the READ is simply dropped.
    function automatic state_e phase_after(input state_e cur, input logic do_wr,
                                           input logic do_rd, input logic do_stp);
        state_e nxt;
        nxt = S_IDLE;
        case (cur)
            S_START: begin
                if (do_wr)       nxt = S_WRITE;
                else if (do_rd)  nxt = S_READ;
                else if (do_stp) nxt = S_STOP;
                else             nxt = S_IDLE;
            end
            S_WRITE, S_READ: nxt = do_stp ? S_STOP : S_IDLE;
            default:         nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period timer: each quarter lasts DIVIDER+1 clk cycles. tick_o marks
// the last cycle of a quarter; quarter_o is the q0-q3 index. hold_i freezes the
// count (slave clock stretching). Counter is cleared whenever run_i is low.
module i2c_quarter_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run_i,
    input  logic        hold_i,
    input  logic [15:0] divider_i,
    output logic        tick_o,
    output logic [1:0]  quarter_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  quarter_q, quarter_d;

    assign tick_o    = run_i && !hold_i && (cnt_q == divider_i);
    assign quarter_o = quarter_q;

    // Next count: reset when idle, wrap on tick, freeze while held.
    always_comb begin
        cnt_d     = cnt_q;
        quarter_d = quarter_q;
        if (!run_i) begin
            cnt_d     = 16'd0;
            quarter_d = 2'd0;
        end else if (tick_o) begin
            cnt_d     = 16'd0;
            quarter_d = quarter_q + 2'd1;
        end else if (!hold_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= 16'd0;
            quarter_q <= 2'd0;
        end else begin
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// I2C single-byte master with a small register interface (DATA, CMD/STATUS,
// DIVIDER). Executes START, WRITE or READ, STOP phases in that order.
// Optional build macro I2C_CLK_STRETCH_EN: hold the quarter counter in q1
// while the slave keeps SCL low; without it scl_in is ignored.
module i2c_byte_master
    import i2c_byte_master_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd124
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        scl_in,
    input  logic        sda_in
);

    state_e      state_q, state_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  txdata_q, txdata_d;
    logic [7:0]  rxdata_q, rxdata_d;
    logic [7:0]  rxsh_q, rxsh_d;
    logic [15:0] divider_q, divider_d;
    logic        done_q, done_d;
    logic        rx_nack_q, rx_nack_d;
    logic        do_wr_q, do_wr_d, do_rd_q, do_rd_d, do_stop_q, do_stop_d;
    logic        ack_out_q, ack_out_d;

    logic        busy, wr_en, tick, hold;
    logic [1:0]  quarter;

    assign busy  = (state_q != S_IDLE);
    assign wr_en = chipselect && !write_n && !busy;

`ifdef I2C_CLK_STRETCH_EN
    assign hold = (quarter == 2'd1) && !scl_in;
`else
    // scl_in is deliberately ignored: timing is purely DIVIDER-driven.
    assign hold = 1'b0 & scl_in;
`endif

    i2c_quarter_timer u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .run_i     (busy),
        .hold_i    (hold),
        .divider_i (divider_q),
        .tick_o    (tick),
        .quarter_o (quarter)
    );

    // Next-state logic: register writes when idle, phase sequencing on ticks.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        txdata_d  = txdata_q;
        rxdata_d  = rxdata_q;
        rxsh_d    = rxsh_q;
        divider_d = divider_q;
        done_d    = done_q;
        rx_nack_d = rx_nack_q;
        do_wr_d   = do_wr_q;
        do_rd_d   = do_rd_q;
        do_stop_d = do_stop_q;
        ack_out_d = ack_out_q;

        if (wr_en) begin
            case (address)
                ADDR_DATA: txdata_d = writedata[7:0];
                ADDR_DIV:  divider_d = writedata;
                ADDR_CMD: begin
                    if (|writedata[3:0]) begin
                        do_wr_d   = writedata[CMD_WRITE];
                        do_rd_d   = writedata[CMD_READ];
                        do_stop_d = writedata[CMD_STOP];
                        ack_out_d = writedata[CMD_ACK_OUT];
                        done_d    = 1'b0;
                        bit_d     = 4'd0;
                        state_d   = writedata[CMD_START] ? S_START :
                                    phase_after(S_START, writedata[CMD_WRITE],
                                                writedata[CMD_READ], writedata[CMD_STOP]);
                    end
                end
                default: ;
            endcase
        end

        if (tick) begin
            if (state_q == S_WRITE && quarter == 2'd2 && bit_q == 4'd8)
                rx_nack_d = sda_in;
            if (state_q == S_READ && quarter == 2'd2 && bit_q < 4'd8)
                rxsh_d = {rxsh_q[6:0], sda_in};
            if (state_q == S_READ && quarter == 2'd3 && bit_q == 4'd7)
                rxdata_d = rxsh_q;
            if (quarter == 2'd3) begin
                case (state_q)
                    S_START: state_d = phase_after(S_START, do_wr_q, do_rd_q, do_stop_q);
                    S_WRITE, S_READ: begin
                        if (bit_q == 4'd8) begin
                            bit_d   = 4'd0;
                            state_d = phase_after(state_q, do_wr_q, do_rd_q, do_stop_q);
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                    S_STOP:  state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end

        if (busy && state_d == S_IDLE)
            done_d = 1'b1;
    end

    // Pad drive per phase and quarter; SDA only changes at q0 of a data bit.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            S_START: begin
                sda_oe = (quarter >= 2'd2);
                scl_oe = (quarter == 2'd3);
            end
            S_WRITE, S_READ: begin
                scl_oe = (quarter == 2'd0) || (quarter == 2'd3);
                if (state_q == S_WRITE && bit_q < 4'd8)
                    sda_oe = ~txdata_q[3'd7 - bit_q[2:0]];
                else if (state_q == S_READ && bit_q == 4'd8)
                    sda_oe = ~ack_out_q;
            end
            S_STOP: begin
                scl_oe = (quarter == 2'd0);
                sda_oe = (quarter <= 2'd1);
            end
            default: ;
        endcase
    end

    // Register read mux; reads have no side effects.
    always_comb begin
        readdata = 16'h0000;
        case (address)
            ADDR_DATA: readdata = {8'h00, rxdata_q};
            ADDR_CMD:  readdata = {13'h0000, done_q, rx_nack_q, busy};
            ADDR_DIV:  readdata = divider_q;
            default:   readdata = 16'h0000;
        endcase
    end

    // State and register file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bit_q     <= 4'd0;
            txdata_q  <= 8'h00;
            rxdata_q  <= 8'h00;
            rxsh_q    <= 8'h00;
            divider_q <= DIV_RESET;
            done_q    <= 1'b0;
            rx_nack_q <= 1'b0;
            do_wr_q   <= 1'b0;
            do_rd_q   <= 1'b0;
            do_stop_q <= 1'b0;
            ack_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            txdata_q  <= txdata_d;
            rxdata_q  <= rxdata_d;
            rxsh_q    <= rxsh_d;
            divider_q <= divider_d;
            done_q    <= done_d;
            rx_nack_q <= rx_nack_d;
            do_wr_q   <= do_wr_d;
            do_rd_q   <= do_rd_d;
            do_stop_q <= do_stop_d;
            ack_out_q <= ack_out_d;
        end
    end

endmodule

// File: doc/i2c_byte_master.md
I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 Parameter DIV_RESET, default 124, reset value of DIVIDER (50 MHz clk -> 100 kHz SCL).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 address  input  2  register select: 0 DATA, 1 CMD/STATUS, 2 DIVIDER, 3 reserved.
REQ-005 chipselect  input  1  slave select; qualifies write_n.
REQ-006 write_n  input  1  active-low write strobe, single-cycle.
REQ-007 writedata  input  16  write data.
REQ-008 readdata  output  16  combinational read mux of addressed register; reads have no side effects.
REQ-009 scl_oe  output  1  1 = pull SCL pad low, 0 = release.
REQ-010 sda_oe  output  1  1 = pull SDA pad low, 0 = release.
REQ-011 scl_in  input  1  SCL pad level, pre-synchronised.
REQ-012 sda_in  input  1  SDA pad level, pre-synchronised.

Function
REQ-013 Write address 0 when idle SHALL load TXDATA[7:0]; read address 0 SHALL return {8'h0, RXDATA}.
REQ-014 Write address 1 when idle SHALL accept CMD bits: 0 START, 1 STOP, 2 WRITE, 3 READ, 4 ACK_OUT (0 = ACK, 1 = NACK after read).
REQ-015 Read address 1 SHALL return STATUS: bit0 BUSY, bit1 RX_NACK, bit2 DONE (sticky), others 0.
REQ-016 Address 2 SHALL read/write DIVIDER[15:0]; quarter-period = DIVIDER+1 clk cycles.
REQ-017 Writes to addresses 0, 1 or 2 while BUSY SHALL be ignored.
REQ-018 An accepted CMD SHALL clear DONE and set BUSY on the next clk edge; a CMD with none of bits 0-3 set SHALL be ignored.
REQ-019 Phase order SHALL be START, then WRITE or READ, then STOP; absent phases skipped; WRITE and READ together: WRITE executes, READ dropped.
REQ-020 States: IDLE, START, WRITE (8 data bits + ACK sample), READ (8 data bits + ACK drive), STOP; every bit, START and STOP SHALL last exactly 4 quarters (q0-q3).
REQ-021 START: q0-q1 SDA/SCL released; q2 SDA low; q3 SDA and SCL low.
REQ-022 Data bit: q0 SCL low, SDA set; q1-q2 SCL released; q3 SCL low; SDA changes only in q0.
REQ-023 WRITE SHALL send TXDATA MSB first, release SDA for bit 9, latch sda_in into RX_NACK in the last cycle of q2.
REQ-024 READ SHALL release SDA for 8 bits, shift sda_in MSB first in the last cycle of q2, then drive ACK_OUT in bit 9; RXDATA updated at end of byte.
REQ-025 STOP: q0 SCL and SDA low; q1 SCL released; q2-q3 both released.
REQ-026 On completion SHALL clear BUSY and set DONE on the same edge; return to IDLE with both oe = 0.
REQ-027 DIVIDER = 0 SHALL give 1-cycle quarters; START+WRITE+STOP at DIVIDER = 0 SHALL hold BUSY for exactly 44 cycles.

Reset
REQ-028 reset_n low, at any time including mid-transfer, SHALL force IDLE, scl_oe = sda_oe = 0, BUSY = DONE = RX_NACK = 0, TXDATA = RXDATA = 0, DIVIDER = DIV_RESET, quarter counter 0.

Configuration
REQ-029 Macro I2C_CLK_STRETCH_EN defined: quarter counter SHALL hold in q1 while scl_in = 0 (slave clock stretching), without timeout.
REQ-030 Macro undefined: scl_in SHALL be ignored and timing is purely DIVIDER-driven.

Structure
REQ-031 Package i2c_byte_master_pkg SHALL hold the state enum, register address constants and CMD/STATUS bit indices.
REQ-032 Sub-module i2c_quarter_timer SHALL generate the quarter tick and q0-q3 index from DIVIDER, with a hold input for stretching.

Verification
REQ-033 Reset, read address 2 -> 124; read address 1 -> 0.
REQ-034 DIVIDER = 0, TXDATA = 8'hA5, CMD = 8'h07, slave ACKs -> SDA bits 1010_0101 on SCL high, RX_NACK = 0, BUSY 44 cycles, DONE = 1.
REQ-035 CMD = 8'h1A, slave drives 8'h3C -> RXDATA = 8'h3C, SDA released (NACK) in bit 9, STOP generated.
REQ-036 Write TXDATA = 8'hFF while BUSY -> TXDATA unchanged; no ACK from slave -> RX_NACK = 1.
REQ-037 reset_n pulsed low at bit 4 of WRITE -> scl_oe = sda_oe = 0 immediately, STATUS = 0.
REQ-038 With I2C_CLK_STRETCH_EN, scl_in held low 10 cycles in q1 -> bit lengthened by exactly 10 cycles; without macro -> no lengthening.
